saw_receiver: RTL

Stop-and-wait ARQ receive stage. It sits directly downstream of the SAW transmitter across the channel model and consumes its `{payload, CRC}` frames. It recomputes the CRC over the payload, delivers good payloads through a valid/ready handshake, and returns a one-cycle `ack` or `nack` toward the transmitter-side ARQ FSM. It also keeps a saturating count of CRC failures.

---
 rtl/saw_receiver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/saw_receiver.sv
`default_nettype none
// ============================================================================
// Module   : saw_receiver
// Purpose  : Stop-and-wait ARQ receive stage. Checks the CRC-8 of each
//            received {payload, CRC} frame. It hands good payloads to the sink
//            through a valid/ready handshake. It answers the transmitter with
//            a one-cycle ack or nack, and it keeps a saturating count of CRC
//            failures.
// Options  : SAW_RX_SEQ_EN - when defined, payload bit BW-1 is an alternating
//            sequence bit. A good frame that carries the wrong sequence bit is
//            a duplicate. A duplicate is acknowledged but not delivered.
// Revision : 1.0 - initial release
// ============================================================================
module saw_receiver #(
  parameter int BW        = 40,
  parameter int CRC_BW    = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BW+CRC_BW-1:0]  frame_in,
  input  logic                  frame_valid,
  output logic [BW-1:0]         data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  ack,
  output logic                  nack,
  output logic                  busy,
  output logic [ERR_CNT_W-1:0]  crc_err_cnt
);

  // CRC-8 polynomial x^8+x^2+x+1. The x^8 term is implicit.
  localparam logic [CRC_BW-1:0] C_CRC_POLY = CRC_BW'(8'h07);

  localparam logic [1:0] C_ST_IDLE    = 2'd0;
  localparam logic [1:0] C_ST_CHECK   = 2'd1;
  localparam logic [1:0] C_ST_DELIVER = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [BW+CRC_BW-1:0] frame_q, frame_d;
  logic [BW-1:0]        data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 ack_q, ack_d;
  logic                 nack_q, nack_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
`ifdef SAW_RX_SEQ_EN
  logic                 expected_seq_q, expected_seq_d;
`endif

  logic [BW-1:0]        w_payload;
  logic [CRC_BW-1:0]    w_rx_crc;
  logic                 w_crc_ok;

  // Bit-serial, MSB-first CRC with init 0. Feeding only the payload bits
  // through this loop yields the remainder of {payload, CRC_BW'b0}.
  function automatic logic [CRC_BW-1:0] crc_calc(input logic [BW-1:0] payload);
    logic [CRC_BW-1:0] crc;
    logic              fb;
    crc = '0;
    for (int i = BW - 1; i >= 0; i--) begin
      fb  = crc[CRC_BW-1] ^ payload[i];
      crc = {crc[CRC_BW-2:0], 1'b0} ^ (fb ? C_CRC_POLY : '0);
    end
    return crc;
  endfunction

  assign w_payload = frame_q[BW+CRC_BW-1:CRC_BW];
  assign w_rx_crc  = frame_q[CRC_BW-1:0];
  assign w_crc_ok  = (crc_calc(w_payload) == w_rx_crc);

  // Next-state logic: capture in IDLE, judge in CHECK, hand off in DELIVER
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    ack_d        = 1'b0;
    nack_d       = 1'b0;
    cnt_d        = cnt_q;
`ifdef SAW_RX_SEQ_EN
    expected_seq_d = expected_seq_q;
`endif
    case (state_q)
      C_ST_IDLE: begin
        if (frame_valid) begin
          frame_d = frame_in;
          state_d = C_ST_CHECK;
        end
      end
      C_ST_CHECK: begin
        if (!w_crc_ok) begin
          nack_d  = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
          end
          state_d = C_ST_IDLE;
`ifdef SAW_RX_SEQ_EN
        end else if (w_payload[BW-1] != expected_seq_q) begin
          // Duplicate: the previous ack was lost, so acknowledge it again.
          ack_d   = 1'b1;
          state_d = C_ST_IDLE;
`endif
        end else begin
          data_out_d   = w_payload;
          data_valid_d = 1'b1;
          state_d      = C_ST_DELIVER;
        end
      end
      C_ST_DELIVER: begin
        // The ack is held back until the sink takes the payload. This is the
        // flow control that throttles the transmitter.
        if (data_valid_q && data_ready) begin
          data_valid_d = 1'b0;
          ack_d        = 1'b1;
          state_d      = C_ST_IDLE;
`ifdef SAW_RX_SEQ_EN
          expected_seq_d = ~expected_seq_q;
`endif
        end
      end
      default: begin
        state_d = C_ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= C_ST_IDLE;
      frame_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      nack_q       <= 1'b0;
      cnt_q        <= '0;
`ifdef SAW_RX_SEQ_EN
      expected_seq_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      ack_q        <= ack_d;
      nack_q       <= nack_d;
      cnt_q        <= cnt_d;
`ifdef SAW_RX_SEQ_EN
      expected_seq_q <= expected_seq_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign ack         = ack_q;
  assign nack        = nack_q;
  assign busy        = (state_q != C_ST_IDLE);
  assign crc_err_cnt = cnt_q;

endmodule
`default_nettype wire
